// File: rtl/tlc_signal_monitor.sv
// Conflict monitor between the traffic-light controller and the lamp drivers.
// It passes the lamp codes through with one cycle of latency. When it sees a
// bad sample it latches a fault, forces both approaches to RED and raises a
// flash strobe until an operator clear is accepted.
module tlc_signal_monitor #(
    parameter int YELLOW_MIN = 6,
    parameter int YELLOW_MAX = 12,
    parameter int CNT_W      = 6,
    parameter int FLASH_HALF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] h_s,
    input  logic [1:0] f_s,
    input  logic       fault_clr,
    output logic [1:0] safe_h,
    output logic [1:0] safe_f,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash,
    output logic [3:0] fault_count
);

    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] GRN = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    localparam logic [CNT_W-1:0] Y_MIN   = CNT_W'(YELLOW_MIN);
    localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(YELLOW_MAX);
    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    localparam int              FL_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        LATCHED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       prev_h;
    logic [1:0]       prev_f;
    logic [CNT_W-1:0] dwell_h;
    logic [CNT_W-1:0] dwell_f;
    logic [CNT_W-1:0] dwell_h_next;
    logic [CNT_W-1:0] dwell_f_next;
    logic [FL_W-1:0]  flash_cnt;
    logic [2:0]       viol;

    logic conflict;
    logic bad_enc;
    logic bad_trans;
    logic short_y;
    logic long_y;
    logic clr_ok;

    // A move into or out of the illegal code is treated as an encoding
    // fault, not a transition fault, so it is accepted here.
    function automatic logic trans_ok(input logic [1:0] p, input logic [1:0] c);
        logic ok;
        ok = 1'b0;
        if (p == c || p == BAD || c == BAD) begin
            ok = 1'b1;
        end else begin
            case ({p, c})
                {GRN, YEL}: ok = 1'b1;
                {YEL, RED}: ok = 1'b1;
                {RED, GRN}: ok = 1'b1;
                default:    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Yellow dwell: load 1 on entry, count further yellows, saturate, clear on exit.
    function automatic logic [CNT_W-1:0] dwell_step(input logic [1:0] p, input logic [1:0] c,
                                                    input logic [CNT_W-1:0] d);
        logic [CNT_W-1:0] n;
        if (c != YEL) begin
            n = '0;
        end else if (p != YEL) begin
            n = CNT_W'(1);
        end else if (d == CNT_TOP) begin
            n = d;
        end else begin
            n = d + CNT_W'(1);
        end
        return n;
    endfunction

    assign conflict  = (h_s != RED) && (f_s != RED);
    assign bad_enc   = (h_s == BAD) || (f_s == BAD);
    assign bad_trans = !trans_ok(prev_h, h_s) || !trans_ok(prev_f, f_s);
    assign short_y   = (prev_h == YEL && h_s == RED && dwell_h < Y_MIN) ||
                       (prev_f == YEL && f_s == RED && dwell_f < Y_MIN);
    assign long_y    = (h_s == YEL && dwell_h == Y_MAX) ||
                       (f_s == YEL && dwell_f == Y_MAX);
    assign clr_ok    = fault_clr && (h_s == RED) && (f_s == RED);

    // INIT has no valid history, so the dwell counters restart from the sample itself.
    assign dwell_h_next = dwell_step((state == INIT) ? RED : prev_h, h_s, dwell_h);
    assign dwell_f_next = dwell_step((state == INIT) ? RED : prev_f, f_s, dwell_f);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Violation priority and next-state selection; the lowest fault code wins.
    always_comb begin
        state_next = state;
        viol       = 3'd0;
        case (state)
            INIT: begin
                if (conflict) begin
                    viol = 3'd1;
                end else if (bad_enc) begin
                    viol = 3'd3;
                end
                state_next = (viol != 3'd0) ? LATCHED : RUN;
            end
            RUN: begin
                if (conflict) begin
                    viol = 3'd1;
                end else if (bad_trans) begin
                    viol = 3'd2;
                end else if (bad_enc) begin
                    viol = 3'd3;
                end else if (short_y) begin
                    viol = 3'd4;
                end else if (long_y) begin
                    viol = 3'd5;
                end
                if (viol != 3'd0) begin
                    state_next = LATCHED;
                end
            end
            LATCHED: begin
                if (clr_ok) begin
                    state_next = INIT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    // History, dwell counters, lamp outputs and fault reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_h      <= RED;
            prev_f      <= RED;
            dwell_h     <= '0;
            dwell_f     <= '0;
            safe_h      <= RED;
            safe_f      <= RED;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            flash       <= 1'b0;
            flash_cnt   <= '0;
            fault_count <= 4'd0;
        end else if (state == LATCHED) begin
            safe_h <= RED;
            safe_f <= RED;
            if (clr_ok) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
                flash      <= 1'b0;
                flash_cnt  <= '0;
            end else if (flash_cnt == FL_LAST) begin
                flash     <= ~flash;
                flash_cnt <= '0;
            end else begin
                flash_cnt <= flash_cnt + FL_W'(1);
            end
        end else begin
            prev_h  <= h_s;
            prev_f  <= f_s;
            dwell_h <= dwell_h_next;
            dwell_f <= dwell_f_next;
            if (viol != 3'd0) begin
                safe_h     <= RED;
                safe_f     <= RED;
                fault      <= 1'b1;
                fault_code <= viol;
                flash      <= 1'b1;
                flash_cnt  <= '0;
                if (fault_count != 4'hF) begin
                    fault_count <= fault_count + 4'd1;
                end
            end else begin
                safe_h <= h_s;
                safe_f <= f_s;
            end
        end
    end

endmodule

// File: tb/tb_tlc_signal_monitor.sv
// Scoreboard bench for tlc_signal_monitor: directed lamp sequences push the
// expected registered outputs, and a monitor compares them one cycle later.
module tb_tlc_signal_monitor;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] h_s;
    logic [1:0] f_s;
    logic       fault_clr;
    logic [1:0] safe_h;
    logic [1:0] safe_f;
    logic       fault;
    logic [2:0] fault_code;
    logic       flash;
    logic [3:0] fault_count;

    typedef struct {
        logic [1:0] sh;
        logic [1:0] sf;
        logic       flt;
        logic [2:0] code;
        logic       fl;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    logic [3:0] exp_cnt   = 4'd0;
    logic       exp_flash = 1'b0;
    logic [2:0] exp_code  = 3'd0;

    tlc_signal_monitor #(
        .YELLOW_MIN(6),
        .YELLOW_MAX(12),
        .CNT_W(6),
        .FLASH_HALF(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .h_s(h_s),
        .f_s(f_s),
        .fault_clr(fault_clr),
        .safe_h(safe_h),
        .safe_f(safe_f),
        .fault(fault),
        .fault_code(fault_code),
        .flash(flash),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    // Drive one sample on the falling edge and queue what the outputs must be after the next rising edge.
    task automatic step(input logic [1:0] h, input logic [1:0] f, input logic c, input logic r,
                        input string nm, input logic [1:0] eh, input logic [1:0] ef,
                        input logic eflt, input logic [2:0] ecode, input logic efl,
                        input logic [3:0] ecnt);
        exp_t e;
        @(negedge clk);
        h_s       = h;
        f_s       = f;
        fault_clr = c;
        rst       = r;
        e.sh   = eh;
        e.sf   = ef;
        e.flt  = eflt;
        e.code = ecode;
        e.fl   = efl;
        e.cnt  = ecnt;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic t_reset(input logic [1:0] h, input logic [1:0] f, input string nm);
        exp_cnt   = 4'd0;
        exp_flash = 1'b0;
        exp_code  = 3'd0;
        step(h, f, 1'b0, 1'b1, nm, R, R, 1'b0, 3'd0, 1'b0, 4'd0);
    endtask

    task automatic t_ok(input logic [1:0] h, input logic [1:0] f, input string nm);
        step(h, f, 1'b0, 1'b0, nm, h, f, 1'b0, 3'd0, 1'b0, exp_cnt);
    endtask

    task automatic t_fault(input logic [1:0] h, input logic [1:0] f, input logic [2:0] code,
                           input string nm);
        if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        exp_flash = 1'b1;
        exp_code  = code;
        step(h, f, 1'b0, 1'b0, nm, R, R, 1'b1, code, 1'b1, exp_cnt);
    endtask

    task automatic t_hold(input logic [1:0] h, input logic [1:0] f, input logic c, input string nm);
        exp_flash = ~exp_flash;
        step(h, f, c, 1'b0, nm, R, R, 1'b1, exp_code, exp_flash, exp_cnt);
    endtask

    task automatic t_clear(input string nm);
        exp_flash = 1'b0;
        exp_code  = 3'd0;
        step(R, R, 1'b1, 1'b0, nm, R, R, 1'b0, 3'd0, 1'b0, exp_cnt);
    endtask

    // Monitor: outputs are registered every cycle, so one queued entry is consumed per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (safe_h !== e.sh || safe_f !== e.sf || fault !== e.flt ||
                    fault_code !== e.code || flash !== e.fl || fault_count !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: got h=%0d f=%0d fault=%0d code=%0d flash=%0d cnt=%0d, want h=%0d f=%0d fault=%0d code=%0d flash=%0d cnt=%0d",
                             e.name, safe_h, safe_f, fault, fault_code, flash, fault_count,
                             e.sh, e.sf, e.flt, e.code, e.fl, e.cnt);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        h_s       = R;
        f_s       = R;
        fault_clr = 1'b0;

        // Reset state, then the INIT cycle.
        t_reset(R, R, "reset0");
        t_reset(G, G, "reset1");
        t_ok(R, R, "init");

        // Normal cycle: highway then farm road.
        for (int i = 0; i < 20; i++) t_ok(G, R, "norm_hg");
        for (int i = 0; i < 6; i++)  t_ok(Y, R, "norm_hy");
        t_ok(R, R, "norm_hr");
        for (int i = 0; i < 10; i++) t_ok(R, G, "norm_fg");
        for (int i = 0; i < 6; i++)  t_ok(R, Y, "norm_fy");
        t_ok(R, R, "norm_fr");
        t_ok(R, R, "norm_idle");

        // Conflicting greens, flash toggling, ignored and accepted clears.
        t_fault(G, G, 3'd1, "conflict");
        t_hold(G, G, 1'b0, "flash_a");
        t_hold(G, G, 1'b0, "flash_b");
        t_hold(G, G, 1'b0, "flash_c");
        t_hold(G, R, 1'b1, "clr_ignored");
        t_hold(R, R, 1'b0, "no_clr");
        t_clear("clr_ok");
        t_ok(R, R, "reinit");
        t_ok(R, R, "rerun");

        // Illegal code together with a conflict: conflict wins.
        t_fault(X, G, 3'd1, "x_and_green");
        t_hold(R, R, 1'b0, "x_hold");
        t_clear("x_clr");
        t_ok(R, R, "x_init");
        t_ok(R, R, "x_run");

        // GREEN->RED is an illegal transition.
        t_ok(G, R, "tr_green");
        t_fault(R, R, 3'd2, "green_to_red");
        t_clear("tr_clr");
        t_ok(R, R, "tr_init");
        t_ok(R, R, "tr_run");

        // Short yellow: 3 samples then RED.
        t_ok(G, R, "sy_green");
        for (int i = 0; i < 3; i++) t_ok(Y, R, "sy_yellow");
        t_fault(R, R, 3'd4, "short_yellow");
        t_clear("sy_clr");
        t_ok(R, R, "sy_init");
        t_ok(R, R, "sy_run");

        // Long yellow: 12 samples allowed, the 13th faults.
        t_ok(G, R, "ly_green");
        for (int i = 0; i < 12; i++) t_ok(Y, R, "ly_yellow");
        t_fault(Y, R, 3'd5, "long_yellow");
        t_hold(Y, R, 1'b0, "ly_hold");
        t_clear("ly_clr");
        t_ok(R, R, "ly_init");
        t_ok(R, R, "ly_run");

        // Exactly YELLOW_MAX yellows then RED is legal.
        t_ok(G, R, "y12_green");
        for (int i = 0; i < 12; i++) t_ok(Y, R, "y12_yellow");
        t_ok(R, R, "y12_red");
        t_ok(R, R, "y12_idle");

        // Fault counter saturates at 15.
        for (int i = 0; i < 11; i++) begin
            t_fault(G, G, 3'd1, "sat_fault");
            t_clear("sat_clr");
            t_ok(R, R, "sat_init");
        end
        t_fault(G, G, 3'd1, "sat_last");
        t_hold(G, G, 1'b0, "sat_hold");

        // Reset while latched clears everything including the counter.
        t_reset(G, G, "rst_mid_fault");
        t_ok(R, R, "post_rst_init");
        t_ok(R, R, "post_rst_run");
        t_ok(G, R, "post_rst_green");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        stim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against the run never reaching its end.
    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout: got no completion after 200000 time units, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
